// File: rtl/sseg_scroll_src.sv
// Scrolling message source for a 4-digit seven-segment multiplexer: stores up to
// 16 hex chars and slides them right-to-left through a 4-digit window.
// Optional build macro DP_MARK_EN lights the dp of the digit showing the last char.
module sseg_scroll_src #(
  parameter int TICK_N = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_data,
  input  logic       clear,
  input  logic       pause,
  output logic       full,
  output logic [4:0] len,
  output logic [7:0] in3,
  output logic [7:0] in2,
  output logic [7:0] in1,
  output logic [7:0] in0
);

  localparam logic [TICK_N-1:0] CNT_ONE = TICK_N'(1);
  localparam logic [7:0]        BLANK   = 8'hFF;

  logic [3:0]        mem_q [16];
  logic [4:0]        len_q, len_d;
  logic              full_q, full_d;
  logic [4:0]        p_q, p_d;
  logic [TICK_N-1:0] cnt_q, cnt_d;
  logic [7:0]        seg_q [4];
  logic [7:0]        seg_d [4];

  logic [4:0] virt_len;
  logic       running;
  logic       tick;
  logic       wr_fire;

  function automatic logic [7:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_seg = 8'hC0;  4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;  4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;  4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;  4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;  4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;  4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;  4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;  default: hex_seg = 8'h8E;
    endcase
  endfunction

  // Message plus a 4-blank gap, so the text scrolls fully out before re-entering.
  assign virt_len = len_q + 5'd4;
  assign running  = !pause && (len_q != 5'd0);
  assign tick     = running && (cnt_q == '1);

  always_comb begin
    len_d   = len_q;
    full_d  = full_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    wr_fire = 1'b0;
    if (clear) begin
      len_d  = 5'd0;
      full_d = 1'b0;
      p_d    = 5'd0;
      cnt_d  = '0;
    end else begin
      if (running) begin
        cnt_d = cnt_q + CNT_ONE;
        if (tick) p_d = (p_q == virt_len - 5'd1) ? 5'd0 : p_q + 5'd1;
      end
      if (wr_en && !full_q) begin
        wr_fire = 1'b1;
        len_d   = len_q + 5'd1;
        full_d  = (len_q == 5'd15);
      end
    end
  end

  // p < virt_len always holds, so one conditional subtract wraps p+k back into range.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      logic [4:0] j;
      j = p_q + 5'(k);
      if (j >= virt_len) j = j - virt_len;
      seg_d[3-k] = (j < len_q) ? hex_seg(mem_q[j[3:0]]) : BLANK;
`ifdef DP_MARK_EN
      if ((len_q != 5'd0) && (j == len_q - 5'd1)) seg_d[3-k][7] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q  <= 5'd0;
      full_q <= 1'b0;
      p_q    <= 5'd0;
      cnt_q  <= '0;
      for (int k = 0; k < 4; k++) seg_q[k] <= BLANK;
    end else begin
      len_q  <= len_d;
      full_q <= full_d;
      p_q    <= p_d;
      cnt_q  <= cnt_d;
      for (int k = 0; k < 4; k++) seg_q[k] <= seg_d[k];
    end
  end

  // NOTE: the character store has no reset; slots at or beyond len are never shown,
  // so clearing it would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[len_q[3:0]] <= wr_data;
  end

  assign full = full_q;
  assign len  = len_q;
  assign in3  = seg_q[3];
  assign in2  = seg_q[2];
  assign in1  = seg_q[1];
  assign in0  = seg_q[0];

endmodule

// File: tb/tb_sseg_scroll_src.sv
// Directed bench for sseg_scroll_src with TICK_N=4 (one scroll tick per 16 clocks).
// Expected patterns honour DP_MARK_EN when the bench is built with it.
module tb_sseg_scroll_src;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_data;
  logic       clear;
  logic       pause;
  logic       full;
  logic [4:0] len;
  logic [7:0] in3, in2, in1, in0;

  int checks = 0;
  int errors = 0;

`ifdef DP_MARK_EN
  localparam logic DP_BIT = 1'b0;
`else
  localparam logic DP_BIT = 1'b1;
`endif

  sseg_scroll_src #(.TICK_N(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .clear  (clear),
    .pause  (pause),
    .full   (full),
    .len    (len),
    .in3    (in3),
    .in2    (in2),
    .in1    (in1),
    .in0    (in0)
  );

  always #5 clk = ~clk;

  // Pattern of the digit showing the final message character.
  function automatic logic [7:0] lc(input logic [7:0] x);
    lc = {DP_BIT, x[6:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
    check({tag, ".in3"}, in3, e3);
    check({tag, ".in2"}, in2, e2);
    check({tag, ".in1"}, in1, e1);
    check({tag, ".in0"}, in0, e0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 4'h0; clear = 1'b0; pause = 1'b0;
    #2;
    check_out("rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("rst.len", {3'b0, len}, 8'd0);
    check("rst.full", {7'b0, full}, 8'd0);
    step(); step();
    reset = 1'b0;

    // Idle with an empty message: everything blank, nothing moves.
    repeat (40) step();
    check_out("idle", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    check("idle.len", {3'b0, len}, 8'd0);
    check("idle.full", {7'b0, full}, 8'd0);

    // Message 1,2,3 (L=7); counter starts the edge after len becomes nonzero.
    wr(4'h1); wr(4'h2); wr(4'h3);
    check("m3.len", {3'b0, len}, 8'd3);
    step();
    check_out("m3.p0", 8'hF9, 8'hA4, lc(8'hB0), 8'hFF);
    repeat (13) step();
    check_out("m3.pretick", 8'hF9, 8'hA4, lc(8'hB0), 8'hFF);
    step();
    check_out("m3.p1", 8'hA4, lc(8'hB0), 8'hFF, 8'hFF);
    repeat (80) step();
    check_out("m3.p6", 8'hFF, 8'hF9, 8'hA4, lc(8'hB0));
    repeat (15) step();
    check_out("m3.p6hold", 8'hFF, 8'hF9, 8'hA4, lc(8'hB0));
    step();
    check_out("m3.wrap", 8'hF9, 8'hA4, lc(8'hB0), 8'hFF);

    // Fill to 16, then one extra write that must be dropped.
    do_clear();
    check("clr.len", {3'b0, len}, 8'd0);
    for (int i = 0; i < 16; i++) wr(4'(i));
    check("fill.len", {3'b0, len}, 8'd16);
    check("fill.full", {7'b0, full}, 8'd1);
    wr(4'h5);
    check("over.len", {3'b0, len}, 8'd16);
    check("over.full", {7'b0, full}, 8'd1);
    step();
    check_out("fill.p1", 8'hF9, 8'hA4, 8'hB0, 8'h99);
    repeat (176) step();
    check_out("fill.p12", 8'hC6, 8'hA1, 8'h86, lc(8'h8E));
    repeat (48) step();
    check_out("fill.p15", lc(8'h8E), 8'hFF, 8'hFF, 8'hFF);

    // clear beats a simultaneous write.
    clear = 1'b1; wr_en = 1'b1; wr_data = 4'h7;
    step();
    clear = 1'b0; wr_en = 1'b0;
    check("cw.len", {3'b0, len}, 8'd0);
    check("cw.full", {7'b0, full}, 8'd0);
    step();
    check_out("cw.blank", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wr(4'h7);
    check("cw.len1", {3'b0, len}, 8'd1);
    step();
    check_out("cw.seven", lc(8'hF8), 8'hFF, 8'hFF, 8'hFF);

    // Pause at p=2 with counter at 1; the next tick comes 15 edges after release.
    do_clear();
    wr(4'h1); wr(4'h2); wr(4'h3);
    repeat (31) step();
    check_out("pz.p2", lc(8'hB0), 8'hFF, 8'hFF, 8'hFF);
    pause = 1'b1;
    repeat (100) step();
    check_out("pz.held", lc(8'hB0), 8'hFF, 8'hFF, 8'hFF);
    check("pz.len", {3'b0, len}, 8'd3);
    pause = 1'b0;
    repeat (15) step();
    check_out("pz.pretick", lc(8'hB0), 8'hFF, 8'hFF, 8'hFF);
    step();
    check_out("pz.p3", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    repeat (16) step();
    check_out("pz.p4", 8'hFF, 8'hFF, 8'hFF, 8'hF9);

    // End-of-message marker on a two-char message.
    do_clear();
    wr(4'h1); wr(4'h2);
    step();
    check_out("dp.p0", 8'hF9, lc(8'hA4), 8'hFF, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
